// File: rtl/mc_program_sequencer_if.sv
// Host/core-side signal bundle for mc_program_sequencer.
// slave  : the sequencer's view (takes the word stream and core opcode, drives the store/core side).
// master : the host/test view (drives the word stream, observes the store/core side and status).
// Signals:
//   load_start, in_valid, in_ready, in_word, in_last  - program word stream with handshake
//   program_write, program_addr, program_cmd           - program store write port
//   core_rst, core_opcode                              - core reset and executed opcode
//   busy, halted, timeout, overflow, word_count        - status
interface mc_program_sequencer_if #(
  parameter int unsigned ADDR = 8,
  parameter int unsigned CODE = 4,
  parameter int unsigned WORD = ADDR + CODE
);
  logic            load_start;
  logic            in_valid;
  logic            in_ready;
  logic [WORD-1:0] in_word;
  logic            in_last;
  logic            program_write;
  logic [ADDR-1:0] program_addr;
  logic [WORD-1:0] program_cmd;
  logic            core_rst;
  logic [CODE-1:0] core_opcode;
  logic            busy;
  logic            halted;
  logic            timeout;
  logic            overflow;
  logic [ADDR:0]   word_count;

  modport slave (
    input  load_start, in_valid, in_word, in_last, core_opcode,
    output in_ready, program_write, program_addr, program_cmd, core_rst,
           busy, halted, timeout, overflow, word_count
  );

  modport master (
    output load_start, in_valid, in_word, in_last, core_opcode,
    input  in_ready, program_write, program_addr, program_cmd, core_rst,
           busy, halted, timeout, overflow, word_count
  );
endinterface

// File: rtl/mc_program_sequencer.sv
// Boot/run controller for a one-bit MC14500B-style core.
// Loads a stream of program words into consecutive store addresses while holding the core in
// reset, holds reset a few more cycles, then releases the core and watches for a halt opcode or
// a watchdog expiry.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mc_program_sequencer_if.slave: word stream, store write port, core control, status
module mc_program_sequencer #(
  parameter int unsigned     ADDR       = 8,
  parameter int unsigned     CODE       = 4,
  parameter int unsigned     WORD       = ADDR + CODE,
  parameter logic [CODE-1:0] HALT_CODE  = 4'hF,
  parameter int unsigned     RUN_LIMIT  = 1024,
  parameter int unsigned     RST_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  mc_program_sequencer_if.slave bus
);

  localparam int unsigned RunW        = (RUN_LIMIT == 0) ? 1 : $clog2(RUN_LIMIT + 1);
  localparam int unsigned HoldW       = (RST_CYCLES <= 2) ? 1 : $clog2(RST_CYCLES);
  localparam int unsigned RunLastInt  = (RUN_LIMIT == 0) ? 0 : RUN_LIMIT - 1;
  localparam int unsigned HoldLastInt = (RST_CYCLES == 0) ? 0 : RST_CYCLES - 1;
  localparam logic [RunW-1:0]  RunLast  = RunLastInt[RunW-1:0];
  localparam logic [HoldW-1:0] HoldLast = HoldLastInt[HoldW-1:0];
  // Store is full once word_count reaches 2**ADDR.
  localparam logic [ADDR:0]    Full     = {1'b1, {ADDR{1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StHalted, StFault} state_e;

  state_e           state_q, state_d;
  logic [ADDR:0]    wcount_q, wcount_d;
  logic             write_q, write_d;
  logic [ADDR-1:0]  paddr_q, paddr_d;
  logic [WORD-1:0]  cmd_q, cmd_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;
  logic             overflow_q, overflow_d;
  logic             start_session;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wcount_q   <= '0;
      write_q    <= 1'b0;
      paddr_q    <= '0;
      cmd_q      <= '0;
      hold_q     <= '0;
      run_q      <= '0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcount_q   <= wcount_d;
      write_q    <= write_d;
      paddr_q    <= paddr_d;
      cmd_q      <= cmd_d;
      hold_q     <= hold_d;
      run_q      <= run_d;
      halted_q   <= halted_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcount_d      = wcount_q;
    write_d       = 1'b0;
    paddr_d       = paddr_q;
    cmd_d         = cmd_q;
    hold_d        = hold_q;
    run_d         = run_q;
    halted_d      = halted_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;
    start_session = 1'b0;

    unique case (state_q)
      StIdle, StHalted, StFault: begin
        start_session = bus.load_start;
      end
      StLoad: begin
        // in_ready is high throughout LOAD, so in_valid alone marks a handshake.
        if (bus.in_valid) begin
          if (wcount_q == Full) begin
            overflow_d = 1'b1;
            state_d    = StFault;
          end else begin
            write_d  = 1'b1;
            cmd_d    = bus.in_word;
            paddr_d  = wcount_q[ADDR-1:0];
            wcount_d = wcount_q + (ADDR + 1)'(1);
            if (bus.in_last) begin
              state_d = StHold;
              hold_d  = '0;
            end
          end
        end
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          state_d = StRun;
          run_d   = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StRun: begin
        if (bus.load_start) begin
          start_session = 1'b1;
        end else if (bus.core_opcode == HALT_CODE) begin
          // Checked before the watchdog so a halt on the expiry cycle wins.
          halted_d = 1'b1;
          state_d  = StHalted;
        end else if ((RUN_LIMIT != 0) && (run_q == RunLast)) begin
          timeout_d = 1'b1;
          state_d   = StFault;
        end else begin
          run_d = run_q + RunW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_session) begin
      state_d    = StLoad;
      wcount_d   = '0;
      paddr_d    = '0;
      halted_d   = 1'b0;
      timeout_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  assign bus.in_ready      = (state_q == StLoad);
  assign bus.core_rst      = (state_q != StRun);
  assign bus.busy          = (state_q == StLoad) || (state_q == StHold) || (state_q == StRun);
  assign bus.program_write = write_q;
  assign bus.program_addr  = paddr_q;
  assign bus.program_cmd   = cmd_q;
  assign bus.halted        = halted_q;
  assign bus.timeout       = timeout_q;
  assign bus.overflow      = overflow_q;
  assign bus.word_count    = wcount_q;

endmodule

// File: tb/tb_mc_program_sequencer.sv
module tb_mc_program_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ls_a = 1'b0, valid_a = 1'b0;
  logic        ls_b = 1'b0, valid_b = 1'b0;
  logic [11:0] in_word = '0;
  logic        in_last = 1'b0;
  logic [3:0]  opcode = '0;

  always #5 clk = ~clk;

  // Instance A: default geometry, short watchdog. Instance B: 4-word store, watchdog disabled.
  mc_program_sequencer_if #(.ADDR(8), .CODE(4)) ifa ();
  mc_program_sequencer_if #(.ADDR(2), .CODE(4)) ifb ();

  assign ifa.load_start  = ls_a;
  assign ifa.in_valid    = valid_a;
  assign ifa.in_word     = in_word;
  assign ifa.in_last     = in_last;
  assign ifa.core_opcode = opcode;
  assign ifb.load_start  = ls_b;
  assign ifb.in_valid    = valid_b;
  assign ifb.in_word     = in_word[5:0];
  assign ifb.in_last     = in_last;
  assign ifb.core_opcode = opcode;

  mc_program_sequencer #(.ADDR(8), .CODE(4), .HALT_CODE(4'hF), .RUN_LIMIT(16), .RST_CYCLES(2))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mc_program_sequencer #(.ADDR(2), .CODE(4), .HALT_CODE(4'hF), .RUN_LIMIT(0), .RST_CYCLES(2))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] data;
  } wr_t;
  wr_t qa[$];
  wr_t qb[$];
  wr_t e;

  typedef struct {
    logic        ls, v;
    logic [11:0] w;
    logic        last;
    logic [3:0]  op;
    logic        rdy, crst, busy, hlt, tmo;
    logic [8:0]  wc;
  } vec_t;
  vec_t vecs[$];
  vec_t r;
  logic       prev_rdy;
  logic [8:0] prev_wc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ls, input logic v, input logic [11:0] w, input logic last,
                     input logic [3:0] op, input logic rdy, input logic crst, input logic busy,
                     input logic hlt, input logic tmo, input logic [8:0] wc);
    vec_t t;
    t.ls = ls; t.v = v; t.w = w; t.last = last; t.op = op;
    t.rdy = rdy; t.crst = crst; t.busy = busy; t.hlt = hlt; t.tmo = tmo; t.wc = wc;
    vecs.push_back(t);
  endtask

  // Advance to the next falling edge and retire any expected writes; every pushed write must
  // appear on exactly the next cycle.
  task automatic tick();
    @(negedge clk);
    if (ifa.program_write || qa.size() != 0) begin
      if (qa.size() == 0) check("a_spurious_write", 32'(ifa.program_write), 0);
      else begin
        e = qa.pop_front();
        check("a_write_strobe", 32'(ifa.program_write), 1);
        check("a_write_addr", 32'(ifa.program_addr), 32'(e.addr));
        check("a_write_data", 32'(ifa.program_cmd), 32'(e.data));
      end
    end
    if (ifb.program_write || qb.size() != 0) begin
      if (qb.size() == 0) check("b_spurious_write", 32'(ifb.program_write), 0);
      else begin
        e = qb.pop_front();
        check("b_write_strobe", 32'(ifb.program_write), 1);
        check("b_write_addr", 32'(ifb.program_addr), 32'(e.addr));
        check("b_write_data", 32'(ifb.program_cmd), 32'(e.data));
      end
    end
  endtask

  initial begin
    // Load with in_valid held, run 10 cycles, then halt.
    add(1, 0, 12'hBAD, 0, 4'h0, 1, 1, 1, 0, 0, 0);
    add(0, 1, 12'h101, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 12'h202, 0, 4'h0, 1, 1, 1, 0, 0, 2);
    add(0, 1, 12'h3F0, 1, 4'h0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 12'hBAD, 0, 4'h0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 12'hBAD, 0, 4'h0, 0, 0, 1, 0, 0, 3);
    for (int i = 0; i < 10; i++) add(0, 0, 12'hBAD, 0, 4'h1, 0, 0, 1, 0, 0, 3);
    add(0, 0, 12'hBAD, 0, 4'hF, 0, 1, 0, 1, 0, 3);
    add(0, 0, 12'hBAD, 0, 4'h1, 0, 1, 0, 1, 0, 3);
    // Same load with in_valid toggling; idle cycles carry junk data.
    add(1, 0, 12'hBAD, 0, 4'h0, 1, 1, 1, 0, 0, 0);
    add(0, 1, 12'h101, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 12'hEEE, 0, 4'h0, 1, 1, 1, 0, 0, 1);
    add(0, 1, 12'h202, 0, 4'h0, 1, 1, 1, 0, 0, 2);
    add(0, 0, 12'hDDD, 1, 4'h0, 1, 1, 1, 0, 0, 2);
    add(0, 1, 12'h3F0, 1, 4'h0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 12'hBAD, 0, 4'h0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 12'hBAD, 0, 4'h0, 0, 0, 1, 0, 0, 3);
    // Watchdog: 16 RUN cycles without halt, then FAULT.
    for (int i = 0; i < 15; i++) add(0, 0, 12'hBAD, 0, 4'h0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 12'hBAD, 0, 4'h0, 0, 1, 0, 0, 1, 3);
    add(0, 0, 12'hBAD, 0, 4'h0, 0, 1, 0, 0, 1, 3);
    // Halt on the 16th RUN cycle beats the watchdog.
    add(1, 0, 12'hBAD, 0, 4'h0, 1, 1, 1, 0, 0, 0);
    add(0, 1, 12'h0AF, 1, 4'h0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 12'hBAD, 0, 4'h0, 0, 1, 1, 0, 0, 1);
    add(0, 0, 12'hBAD, 0, 4'h0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 15; i++) add(0, 0, 12'hBAD, 0, 4'h0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 12'hBAD, 0, 4'hF, 0, 1, 0, 1, 0, 1);

    // Reset state, observed while rst is still asserted.
    #1;
    check("rst_core_rst", 32'(ifa.core_rst), 1);
    check("rst_in_ready", 32'(ifa.in_ready), 0);
    check("rst_write", 32'(ifa.program_write), 0);
    check("rst_addr", 32'(ifa.program_addr), 0);
    check("rst_cmd", 32'(ifa.program_cmd), 0);
    check("rst_word_count", 32'(ifa.word_count), 0);
    check("rst_flags", {28'd0, ifa.busy, ifa.halted, ifa.timeout, ifa.overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    prev_rdy = 1'b0;
    prev_wc  = '0;
    for (int k = 0; k < vecs.size(); k++) begin
      r       = vecs[k];
      ls_a    = r.ls;
      valid_a = r.v;
      in_word = r.w;
      in_last = r.last;
      opcode  = r.op;
      if (r.v && prev_rdy) qa.push_back('{addr: prev_wc[7:0], data: r.w});
      tick();
      check($sformatf("v%0d_in_ready", k), 32'(ifa.in_ready), 32'(r.rdy));
      check($sformatf("v%0d_core_rst", k), 32'(ifa.core_rst), 32'(r.crst));
      check($sformatf("v%0d_busy", k), 32'(ifa.busy), 32'(r.busy));
      check($sformatf("v%0d_halted", k), 32'(ifa.halted), 32'(r.hlt));
      check($sformatf("v%0d_timeout", k), 32'(ifa.timeout), 32'(r.tmo));
      check($sformatf("v%0d_word_count", k), 32'(ifa.word_count), 32'(r.wc));
      prev_rdy = r.rdy;
      prev_wc  = r.wc;
    end
    ls_a = 1'b0; valid_a = 1'b0; in_last = 1'b0; opcode = 4'h0;

    // Overflow on the 4-word store: five words, no in_last.
    ls_b = 1'b1;
    tick();
    ls_b = 1'b0;
    check("b_load_ready", 32'(ifb.in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      valid_b = 1'b1;
      in_word = 12'(8 + i);
      if (i < 4) qb.push_back('{addr: 8'(i), data: 12'(8 + i)});
      tick();
    end
    valid_b = 1'b0;
    check("b_ovf_flag", 32'(ifb.overflow), 1);
    check("b_ovf_ready", 32'(ifb.in_ready), 0);
    check("b_ovf_core_rst", 32'(ifb.core_rst), 1);
    check("b_ovf_busy", 32'(ifb.busy), 0);
    check("b_ovf_word_count", 32'(ifb.word_count), 4);
    ls_b = 1'b1;
    tick();
    ls_b = 1'b0;
    check("b_reload_ovf_clear", 32'(ifb.overflow), 0);
    check("b_reload_word_count", 32'(ifb.word_count), 0);
    check("b_reload_ready", 32'(ifb.in_ready), 1);
    valid_b = 1'b1; in_word = 12'h015; in_last = 1'b1;
    qb.push_back('{addr: 8'd0, data: 12'h015});
    tick();
    valid_b = 1'b0; in_last = 1'b0;
    check("b_reload_count1", 32'(ifb.word_count), 1);
    tick();
    tick();
    check("b_run_core_rst", 32'(ifb.core_rst), 0);
    for (int i = 0; i < 40; i++) tick();
    check("b_nowdog_timeout", 32'(ifb.timeout), 0);
    check("b_nowdog_core_rst", 32'(ifb.core_rst), 0);
    ls_b = 1'b1;
    tick();
    ls_b = 1'b0;
    check("b_abort_core_rst", 32'(ifb.core_rst), 1);
    check("b_abort_ready", 32'(ifb.in_ready), 1);

    // Reset mid-load after two words, applied between clock edges.
    ls_a = 1'b1;
    tick();
    ls_a = 1'b0;
    valid_a = 1'b1; in_word = 12'h0C1;
    qa.push_back('{addr: 8'd0, data: 12'h0C1});
    tick();
    in_word = 12'h0C2;
    qa.push_back('{addr: 8'd1, data: 12'h0C2});
    tick();
    valid_a = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("mid_rst_core_rst", 32'(ifa.core_rst), 1);
    check("mid_rst_ready", 32'(ifa.in_ready), 0);
    check("mid_rst_write", 32'(ifa.program_write), 0);
    check("mid_rst_addr", 32'(ifa.program_addr), 0);
    check("mid_rst_word_count", 32'(ifa.word_count), 0);
    check("mid_rst_b_ready", 32'(ifb.in_ready), 0);
    #1 rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(ifa.busy), 0);

    // Fresh load after reset starts at address 0; then abort the run with load_start.
    ls_a = 1'b1;
    tick();
    ls_a = 1'b0;
    valid_a = 1'b1; in_word = 12'h5A3; in_last = 1'b1;
    qa.push_back('{addr: 8'd0, data: 12'h5A3});
    tick();
    valid_a = 1'b0; in_last = 1'b0;
    tick();
    tick();
    check("a_run_core_rst", 32'(ifa.core_rst), 0);
    ls_a = 1'b1;
    tick();
    ls_a = 1'b0;
    check("a_abort_core_rst", 32'(ifa.core_rst), 1);
    check("a_abort_ready", 32'(ifa.in_ready), 1);
    check("a_abort_word_count", 32'(ifa.word_count), 0);
    tick();

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
